// File: rtl/ransac_point_reader_pkg.sv
// Shared types and default geometry for the RANSAC point reader.
package ransac_reader_pkg;

    localparam int READER_ADDR_W     = 14;
    localparam int READER_DATA_W     = 32;
    localparam int READER_CNT_W      = 15;
    localparam int READER_FIFO_DEPTH = 4;
    localparam int MEM_WORDS         = 16384;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } reader_state_t;

endpackage

// File: rtl/ransac_point_reader_if.sv
// Memory read port plus point stream; master is the reader, slave is the memory/consumer side.
interface ransac_point_reader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) ();

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] pt_data;
    logic              pt_valid;
    logic              pt_ready;
    logic              pt_last;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output pt_data, pt_valid, pt_last,
        input  mem_readdata, pt_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  pt_data, pt_valid, pt_last,
        output mem_readdata, pt_ready
    );

endinterface

// File: rtl/ransac_point_reader_fifo.sv
// Small synchronous FIFO holding {last, data}; storage-register output, occupancy count exported.
module ransac_reader_fifo
    import ransac_reader_pkg::*;
#(
    parameter int WIDTH = READER_DATA_W + 1,
    parameter int DEPTH = READER_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int COUNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   pop_data,
    output logic [COUNT_W-1:0] count
);

    localparam logic [PTR_W-1:0]   PTR_ONE   = 1;
    localparam logic [COUNT_W-1:0] COUNT_ONE = 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    assign pop_ok   = pop && (count != '0);
    assign pop_data = (count != '0) ? store[rd_ptr] : '0;

    // Flush wins over a same-cycle push so a returning read after abort is discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ransac_point_reader.sv
// Streams WORD_COUNT words from on-chip memory to the RANSAC fit datapath via a credit-limited FIFO.
// Optional running checksum output when READER_CKSUM_EN is defined.
module ransac_point_reader
    import ransac_reader_pkg::*;
#(
    parameter int ADDR_W     = READER_ADDR_W,
    parameter int DATA_W     = READER_DATA_W,
    parameter int CNT_W      = READER_CNT_W,
    parameter int FIFO_DEPTH = READER_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [CNT_W-1:0]       word_count,
    output logic                   busy,
    output logic                   done,
`ifdef READER_CKSUM_EN
    output logic [31:0]            checksum,
`endif
    ransac_point_reader_if.master  bus
);

    localparam int FC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FC_W:0]      DEPTH_LIM = (FC_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = 1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;

    reader_state_t     state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  total;
    logic              inflight;
    logic              inflight_last;
    logic              issue;
    logic              start_ok;
    logic              last_issue;
    logic              credit_ok;
    logic              pop;
    logic [FC_W-1:0]   fifo_count;
    logic [FC_W:0]     occupancy;
    logic [DATA_W:0]   fifo_out;

    assign start_ok   = (state == IDLE) && start && !abort;
    assign occupancy  = {1'b0, fifo_count} + {{FC_W{1'b0}}, inflight};
    assign credit_ok  = occupancy < DEPTH_LIM;
    assign last_issue = (issued == total - CNT_ONE);
    assign pop        = bus.pt_valid && bus.pt_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Reads are only issued while the FIFO plus the outstanding read still leaves a free slot.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = (word_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                issue = (issued < total) && credit_ok;
                if (issue && last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && bus.pt_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            issue      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr          <= '0;
            issued        <= '0;
            total         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && last_issue;
            if (start_ok) begin
                addr   <= base_addr;
                issued <= '0;
                total  <= word_count;
            end else if (issue) begin
                addr   <= addr + ADDR_ONE;
                issued <= issued + CNT_ONE;
            end
        end
    end

    ransac_reader_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (abort),
        .push      (inflight && !abort),
        .push_data ({inflight_last, bus.mem_readdata}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .count     (fifo_count)
    );

    assign bus.mem_address    = addr;
    assign bus.mem_chipselect = issue;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;
    assign bus.pt_valid       = (fifo_count != '0);
    assign bus.pt_data        = fifo_out[DATA_W-1:0];
    assign bus.pt_last        = fifo_out[DATA_W];

`ifdef READER_CKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + bus.pt_data;
        end
    end
`endif

endmodule
